// File: rtl/muldiv_issue_arb_if.sv
// Signal bundle between the harts, the shared muldiv unit and the
// register-file write-back port, as seen by the issue arbiter.
//
// Handshakes: a transfer happens on the rising edge where valid and
// ready are both high. Valid never waits for ready, and the payload
// stays stable while valid is high and ready is low.
// For requests this is req_valid[h] & req_ready[h].
// For write-back it is wb_valid & wb_ready.
interface muldiv_issue_arb_if #(
    parameter int HART_NUM   = 2,
    parameter int HART_ID_W  = 1,
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
);
    logic [HART_NUM-1:0]            req_valid;
    logic [HART_NUM*3-1:0]          req_op;
    logic [HART_NUM*XLEN-1:0]       req_a;
    logic [HART_NUM*XLEN-1:0]       req_b;
    logic [HART_NUM*REG_ADDR_W-1:0] req_rd;
    logic [HART_NUM-1:0]            req_ready;

    logic                  muldiv_start;
    logic [2:0]            muldiv_op;
    logic [XLEN-1:0]       muldiv_a;
    logic [XLEN-1:0]       muldiv_b;
    logic [HART_ID_W-1:0]  muldiv_hart_id;
    logic [REG_ADDR_W-1:0] muldiv_rd;
    logic                  muldiv_busy;
    logic                  muldiv_done;
    logic [XLEN-1:0]       muldiv_result;
    logic [HART_ID_W-1:0]  muldiv_done_hart_id;
    logic [REG_ADDR_W-1:0] muldiv_done_rd;

    logic                  wb_valid;
    logic [HART_ID_W-1:0]  wb_hart_id;
    logic [REG_ADDR_W-1:0] wb_rd;
    logic [XLEN-1:0]       wb_data;
    logic                  wb_ready;

    logic [HART_NUM-1:0]   hart_pending;
    logic                  tag_err;

    // Environment side: harts, muldiv unit and register file.
    modport master (
        output req_valid, req_op, req_a, req_b, req_rd,
        input  req_ready,
        input  muldiv_start, muldiv_op, muldiv_a, muldiv_b, muldiv_hart_id, muldiv_rd,
        output muldiv_busy, muldiv_done, muldiv_result, muldiv_done_hart_id, muldiv_done_rd,
        input  wb_valid, wb_hart_id, wb_rd, wb_data,
        output wb_ready,
        input  hart_pending, tag_err
    );

    // Arbiter side.
    modport slave (
        input  req_valid, req_op, req_a, req_b, req_rd,
        output req_ready,
        output muldiv_start, muldiv_op, muldiv_a, muldiv_b, muldiv_hart_id, muldiv_rd,
        input  muldiv_busy, muldiv_done, muldiv_result, muldiv_done_hart_id, muldiv_done_rd,
        output wb_valid, wb_hart_id, wb_rd, wb_data,
        input  wb_ready,
        output hart_pending, tag_err
    );
endinterface

// File: rtl/muldiv_issue_arb.sv
// Round-robin issue stage for the shared muldiv unit. It allows one
// operation in flight at a time. The unit's done pulse is captured into
// a write-back register, which is held until the register file takes it.
module muldiv_issue_arb #(
    parameter int HART_NUM   = 2,
    parameter int HART_ID_W  = 1,
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    muldiv_issue_arb_if.slave bus,
    output logic [1:0]        dbg_state
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        WB    = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [HART_ID_W-1:0]  rr_ptr;
    logic [HART_ID_W-1:0]  rr_nxt;
    logic [HART_ID_W-1:0]  grant_id;
    logic [HART_ID_W-1:0]  cand_id;
    logic                  grant_any;
    logic                  grant;
    logic [HART_NUM-1:0]   eligible;
    logic [HART_NUM-1:0]   ready;
    int                    cand;

    logic                  start_q;
    logic [2:0]            op_q;
    logic [XLEN-1:0]       a_q;
    logic [XLEN-1:0]       b_q;
    logic [HART_ID_W-1:0]  hart_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic                  wb_valid_q;
    logic [HART_ID_W-1:0]  wb_hart_q;
    logic [REG_ADDR_W-1:0] wb_rd_q;
    logic [XLEN-1:0]       wb_data_q;
    logic [HART_NUM-1:0]   pend_q;
    logic                  tag_err_q;

    // Pick the first eligible hart, searching from rr_ptr and wrapping.
    always_comb begin
        eligible  = bus.req_valid & ~pend_q;
        grant_any = 1'b0;
        grant_id  = '0;
        cand      = 0;
        cand_id   = '0;
        for (int i = 0; i < HART_NUM; i++) begin
            cand = int'(rr_ptr) + i;
            if (cand >= HART_NUM) cand = cand - HART_NUM;
            cand_id = HART_ID_W'(cand);
            if (!grant_any && eligible[cand_id]) begin
                grant_any = 1'b1;
                grant_id  = cand_id;
            end
        end
        grant  = (state == IDLE) && !bus.muldiv_busy && grant_any;
        rr_nxt = (int'(grant_id) == HART_NUM - 1) ? '0 : grant_id + 1'b1;
        ready  = '0;
        if (grant) ready[grant_id] = 1'b1;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic: one op goes from grant, through start and wait, to write-back.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant) state_nxt = START;
            START:   state_nxt = WAIT;
            WAIT:    if (bus.muldiv_done) state_nxt = WB;
            WB:      if (bus.wb_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request latch, done capture, pending bookkeeping and error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr     <= '0;
            start_q    <= 1'b0;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            hart_q     <= '0;
            rd_q       <= '0;
            wb_valid_q <= 1'b0;
            wb_hart_q  <= '0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            pend_q     <= '0;
            tag_err_q  <= 1'b0;
        end else begin
            start_q <= grant;
            if (grant) begin
                op_q             <= bus.req_op[int'(grant_id)*3 +: 3];
                a_q              <= bus.req_a[int'(grant_id)*XLEN +: XLEN];
                b_q              <= bus.req_b[int'(grant_id)*XLEN +: XLEN];
                rd_q             <= bus.req_rd[int'(grant_id)*REG_ADDR_W +: REG_ADDR_W];
                hart_q           <= grant_id;
                pend_q[grant_id] <= 1'b1;
                rr_ptr           <= rr_nxt;
            end
            // A done outside WAIT has no op to belong to. Its data is dropped.
            if (bus.muldiv_done) begin
                if (state == WAIT) begin
                    wb_valid_q <= 1'b1;
                    wb_data_q  <= bus.muldiv_result;
                    wb_hart_q  <= bus.muldiv_done_hart_id;
                    wb_rd_q    <= bus.muldiv_done_rd;
                    if (bus.muldiv_done_hart_id != hart_q || bus.muldiv_done_rd != rd_q)
                        tag_err_q <= 1'b1;
                end else begin
                    tag_err_q <= 1'b1;
                end
            end
            if (wb_valid_q && bus.wb_ready) begin
                wb_valid_q        <= 1'b0;
                pend_q[wb_hart_q] <= 1'b0;
            end
        end
    end

    assign bus.req_ready      = ready;
    assign bus.muldiv_start   = start_q;
    assign bus.muldiv_op      = op_q;
    assign bus.muldiv_a       = a_q;
    assign bus.muldiv_b       = b_q;
    assign bus.muldiv_hart_id = hart_q;
    assign bus.muldiv_rd      = rd_q;
    assign bus.wb_valid       = wb_valid_q;
    assign bus.wb_hart_id     = wb_hart_q;
    assign bus.wb_rd          = wb_rd_q;
    assign bus.wb_data        = wb_data_q;
    assign bus.hart_pending   = pend_q;
    assign bus.tag_err        = tag_err_q;
    assign dbg_state          = state;
endmodule
